// File: rtl/tv80_alu_pkg.sv
// tv80_alu_pkg: shared definitions for the byte-serial TV80 ALU.
//   op_e     - 4-bit opcode encodings (10..15 act as NOP)
//   state_e  - sequencer states
//   kind_e   - operation class handed to the byte slice
//   mode_e   - flag layout selector (Z80 / Game Boy)
//   *_S/Z/.. - flag bit positions for each layout
package tv80_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_ADC = 4'd1,
        OP_SUB = 4'd2,
        OP_SBC = 4'd3,
        OP_AND = 4'd4,
        OP_XOR = 4'd5,
        OP_OR  = 4'd6,
        OP_CP  = 4'd7,
        OP_INC = 4'd8,
        OP_DEC = 4'd9
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        K_ARITH,
        K_AND,
        K_XOR,
        K_OR
    } kind_e;

    typedef enum int unsigned {
        MODE_Z80 = 0,
        MODE_GB  = 3
    } mode_e;

    // Z80 flag byte: S Z Y H X P/V N C
    localparam int unsigned Z80_C = 0;
    localparam int unsigned Z80_N = 1;
    localparam int unsigned Z80_P = 2;
    localparam int unsigned Z80_X = 3;
    localparam int unsigned Z80_H = 4;
    localparam int unsigned Z80_Y = 5;
    localparam int unsigned Z80_Z = 6;
    localparam int unsigned Z80_S = 7;

    // LR35902 flag byte: Z N H C 0 0 0 0
    localparam int unsigned GB_C = 4;
    localparam int unsigned GB_H = 5;
    localparam int unsigned GB_N = 6;
    localparam int unsigned GB_Z = 7;

endpackage

// File: rtl/tv80_alu_byte.sv
// tv80_alu_byte: combinational 8-bit ALU slice.
//   a, b   in  8  operand bytes
//   cin    in  1  carry into bit 0 (add form; subtraction passes ~borrow)
//   sub    in  1  invert b before the adder
//   kind   in  2  arithmetic or bitwise AND/XOR/OR
//   r      out 8  result byte
//   cout   out 1  carry out of bit 7
//   half   out 1  carry out of bit 3
//   c6     out 1  carry out of bit 6 (into bit 7), for overflow
module tv80_alu_byte
    import tv80_alu_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    input  logic       sub,
    input  kind_e      kind,
    output logic [7:0] r,
    output logic       cout,
    output logic       half,
    output logic       c6
);

    logic [7:0] bb;
    logic [4:0] lo;
    logic [3:0] mid;
    logic [1:0] hi;

    // Split adder exposes the bit-3 and bit-6 carries without a second add.
    always_comb begin
        bb  = sub ? ~b : b;
        lo  = {1'b0, a[3:0]} + {1'b0, bb[3:0]} + {4'b0, cin};
        mid = {1'b0, a[6:4]} + {1'b0, bb[6:4]} + {3'b0, lo[4]};
        hi  = {1'b0, a[7]} + {1'b0, bb[7]} + {1'b0, mid[3]};
        cout = hi[1];
        half = lo[4];
        c6   = mid[3];
        case (kind)
            K_AND:   r = a & b;
            K_XOR:   r = a ^ b;
            K_OR:    r = a | b;
            default: r = {hi[0], mid[2:0], lo[3:0]};
        endcase
    end

endmodule

// File: rtl/tv80_alu_mc.sv
// tv80_alu_mc: multi-cycle byte-serial TV80 ALU, WIDTH bits, one byte/clock.
//   clk, reset           clock, async active-high reset
//   in_valid/in_ready    request handshake (op, a, b, f_in, keep_szp)
//   op                   ADD ADC SUB SBC AND XOR OR CP INC DEC, else NOP
//   a, b                 operands (b ignored for INC/DEC)
//   f_in                 incoming flags (carry-in, preserved bits)
//   keep_szp             copy S/Z/P from f_in
//   out_valid/out_ready  result handshake; q, f_out held while stalled
//   q, f_out             result and flag byte (MODE 0 Z80, MODE 3 GB)
module tv80_alu_mc
    import tv80_alu_pkg::*;
#(
    parameter int unsigned MODE  = 3,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [7:0]       f_in,
    input  logic             keep_szp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic [7:0]       f_out
);

    localparam int unsigned NB    = WIDTH / 8;
    localparam int unsigned CW    = (NB > 1) ? $clog2(NB) : 1;
    localparam bit          IS_GB = (MODE == MODE_GB);
    localparam int unsigned C_BIT = IS_GB ? GB_C : Z80_C;
    localparam int unsigned Z_BIT = IS_GB ? GB_Z : Z80_Z;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, q_q, q_d;
    logic             carry_q, carry_d, zacc_q, zacc_d, keep_q, keep_d;
    op_e              op_q, op_d, op_in;
    logic [7:0]       fin_q, fin_d, f_q, f_d;

    logic             is_sub, is_incdec, is_nop, last, accept;
    kind_e            kind;
    logic [7:0]       res;
    logic             cout, half, c6;
    logic             z_all, c_f, h_f, cin0;
    logic [WIDTH-1:0] a_rot, r_shift;
    logic [7:0]       flags;

    always_comb begin
        is_sub    = op_q inside {OP_SUB, OP_SBC, OP_CP, OP_DEC};
        is_incdec = op_q inside {OP_INC, OP_DEC};
        is_nop    = op_q > OP_DEC;
        case (op_q)
            OP_AND:  kind = K_AND;
            OP_XOR:  kind = K_XOR;
            OP_OR:   kind = K_OR;
            default: kind = K_ARITH;
        endcase
    end

    tv80_alu_byte u_byte (
        .a    (a_q[7:0]),
        .b    (b_q[7:0]),
        .cin  (carry_q),
        .sub  (is_sub),
        .kind (kind),
        .r    (res),
        .cout (cout),
        .half (half),
        .c6   (c6)
    );

    // a rotates rather than shifts so the original operand is back in place
    // after NB steps, which is what CP and NOP return as q.
    assign a_rot   = WIDTH'({a_q[7:0], a_q} >> 8);
    assign r_shift = WIDTH'({res, r_q} >> 8);
    assign last    = (cnt_q == CW'(NB - 1));

    assign in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == S_DONE);
    assign q         = q_q;
    assign f_out     = f_q;

    // Flags are formed while the top byte is in the slice.
    always_comb begin
        z_all = zacc_q & (res == 8'h00);
        if (kind == K_ARITH) begin
            c_f = is_sub ? ~cout : cout;
            h_f = is_sub ? ~half : half;
        end else begin
            c_f = 1'b0;
            h_f = (kind == K_AND);
        end
        if (is_incdec) c_f = fin_q[C_BIT];
        flags = '0;
        if (IS_GB) begin
            flags[GB_Z] = keep_q ? fin_q[Z_BIT] : z_all;
            flags[GB_N] = is_sub;
            flags[GB_H] = h_f;
            flags[GB_C] = c_f;
        end else begin
            flags[Z80_S] = keep_q ? fin_q[Z80_S] : res[7];
            flags[Z80_Z] = keep_q ? fin_q[Z_BIT] : z_all;
            flags[Z80_Y] = (op_q == OP_CP) ? b_q[5] : res[5];
            flags[Z80_H] = h_f;
            flags[Z80_X] = (op_q == OP_CP) ? b_q[3] : res[3];
            flags[Z80_P] = keep_q ? fin_q[Z80_P] :
                           (kind == K_ARITH) ? (c6 ^ cout) : ~^res;
            flags[Z80_N] = is_sub;
            flags[Z80_C] = c_f;
        end
        if (is_nop || (is_incdec && WIDTH > 8)) flags = fin_q;
        if (IS_GB) flags[3:0] = '0;
    end

    always_comb begin
        op_in = op_e'(op);
        case (op_in)
            OP_ADC:                 cin0 = f_in[C_BIT];
            OP_SBC:                 cin0 = ~f_in[C_BIT];
            OP_SUB, OP_CP, OP_DEC:  cin0 = 1'b1;
            default:                cin0 = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        carry_d = carry_q;
        zacc_d  = zacc_q;
        op_d    = op_q;
        fin_d   = fin_q;
        keep_d  = keep_q;
        q_d     = q_q;
        f_d     = f_q;
        case (state_q)
            S_RUN: begin
                a_d     = a_rot;
                b_d     = b_q >> 8;
                r_d     = r_shift;
                carry_d = cout;
                zacc_d  = z_all;
                cnt_d   = cnt_q + CW'(1);
                if (last) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                    q_d     = (op_q == OP_CP || is_nop) ? a_rot : r_shift;
                    f_d     = flags;
                end
            end
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: ;
        endcase
        if (accept) begin
            state_d = S_RUN;
            cnt_d   = '0;
            a_d     = a;
            b_d     = (op_in == OP_INC || op_in == OP_DEC) ? WIDTH'(1) : b;
            carry_d = cin0;
            zacc_d  = 1'b1;
            op_d    = op_in;
            fin_d   = f_in;
            keep_d  = keep_szp;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            carry_q <= 1'b0;
            zacc_q  <= 1'b0;
            op_q    <= OP_ADD;
            fin_q   <= '0;
            keep_q  <= 1'b0;
            q_q     <= '0;
            f_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            carry_q <= carry_d;
            zacc_q  <= zacc_d;
            op_q    <= op_d;
            fin_q   <= fin_d;
            keep_q  <= keep_d;
            q_q     <= q_d;
            f_q     <= f_d;
        end
    end

endmodule

// File: tb/tb_tv80_alu_mc.sv
// tb_tv80_alu_mc: four ALU configurations (GB/16, Z80/16, GB/8, Z80/32)
// driven in lockstep from one handshake and compared against a plain
// arithmetic model of the flag rules.
module tb_tv80_alu_mc;

    localparam int M_CFG [4] = '{3, 0, 3, 0};
    localparam int W_CFG [4] = '{16, 16, 8, 32};

    logic        clk = 1'b0;
    logic        reset, in_valid, out_ready, keep;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [7:0]  f_in;

    logic        rv [4];
    logic        vv [4];
    logic [7:0]  fv [4];
    logic [31:0] qv [4];
    logic [15:0] q0, q1;
    logic [7:0]  q2;
    logic [31:0] q3;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [4];
    logic [7:0]  exp_f [4];

    always #5 clk = ~clk;

    tv80_alu_mc #(.MODE(3), .WIDTH(16)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rv[0]), .op(op),
        .a(a[15:0]), .b(b[15:0]), .f_in(f_in), .keep_szp(keep),
        .out_valid(vv[0]), .out_ready(out_ready), .q(q0), .f_out(fv[0]));
    tv80_alu_mc #(.MODE(0), .WIDTH(16)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rv[1]), .op(op),
        .a(a[15:0]), .b(b[15:0]), .f_in(f_in), .keep_szp(keep),
        .out_valid(vv[1]), .out_ready(out_ready), .q(q1), .f_out(fv[1]));
    tv80_alu_mc #(.MODE(3), .WIDTH(8)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rv[2]), .op(op),
        .a(a[7:0]), .b(b[7:0]), .f_in(f_in), .keep_szp(keep),
        .out_valid(vv[2]), .out_ready(out_ready), .q(q2), .f_out(fv[2]));
    tv80_alu_mc #(.MODE(0), .WIDTH(32)) dut3 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rv[3]), .op(op),
        .a(a), .b(b), .f_in(f_in), .keep_szp(keep),
        .out_valid(vv[3]), .out_ready(out_ready), .q(q3), .f_out(fv[3]));

    assign qv[0] = {16'b0, q0};
    assign qv[1] = {16'b0, q1};
    assign qv[2] = {24'b0, q2};
    assign qv[3] = q3;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic void model(input int mode, input int w, input logic [3:0] o,
                                  input logic [31:0] ai, input logic [31:0] bi,
                                  input logic [7:0] fin, input logic kp,
                                  output logic [31:0] qo, output logic [7:0] fo);
        longint unsigned m, hm, aa, bb, ci, t, res;
        logic [7:0] tb;
        logic s, z, h, v, n, c, cb, nop;
        m   = (64'd1 << w) - 1;
        hm  = (64'd1 << (w - 4)) - 1;
        aa  = {32'b0, ai} & m;
        bb  = {32'b0, bi} & m;
        cb  = (mode == 3) ? fin[4] : fin[0];
        nop = (o > 4'd9);
        if (o == 4'd8 || o == 4'd9) bb = 1;
        n = 0; h = 0; c = 0; v = 0; res = aa;
        case (o)
            4'd0, 4'd1, 4'd8: begin
                ci  = (o == 4'd1) ? 64'(cb) : 64'd0;
                t   = aa + bb + ci;
                c   = t[w];
                res = t & m;
                t   = (aa & hm) + (bb & hm) + ci;
                h   = t[w - 4];
                v   = (aa[w-1] == bb[w-1]) && (res[w-1] != aa[w-1]);
            end
            4'd2, 4'd3, 4'd7, 4'd9: begin
                ci  = (o == 4'd3) ? 64'(cb) : 64'd0;
                res = (aa - bb - ci) & m;
                c   = (aa < bb + ci);
                h   = ((aa & hm) < (bb & hm) + ci);
                v   = (aa[w-1] != bb[w-1]) && (res[w-1] != aa[w-1]);
                n   = 1;
            end
            4'd4: begin res = aa & bb; h = 1; end
            4'd5: res = aa ^ bb;
            4'd6: res = aa | bb;
            default: ;
        endcase
        if (o >= 4'd4 && o <= 4'd6) begin
            tb = 8'(res >> (w - 8));
            v  = ($countones(tb) % 2) == 0;
        end
        if (o == 4'd8 || o == 4'd9) c = cb;
        s  = res[w-1];
        z  = (res == 0);
        tb = 8'(((o == 4'd7) ? bb : res) >> (w - 8));
        if (kp) begin
            if (mode == 3) z = fin[7];
            else begin s = fin[7]; z = fin[6]; v = fin[2]; end
        end
        fo = (mode == 3) ? {z, n, h, c, 4'b0} : {s, z, tb[5], h, tb[3], v, n, c};
        if (nop || ((o == 4'd8 || o == 4'd9) && w > 8)) fo = fin;
        if (mode == 3) fo[3:0] = 4'b0;
        qo = (nop || o == 4'd7) ? 32'(aa) : 32'(res);
    endfunction

    task automatic issue(input logic [3:0] o, input logic [31:0] aa, input logic [31:0] bb,
                         input logic [7:0] ff, input logic kk, input logic with_ready);
        @(negedge clk);
        op = o; a = aa; b = bb; f_in = ff; keep = kk;
        in_valid = 1'b1; out_ready = with_ready;
        for (int i = 0; i < 4; i++)
            model(M_CFG[i], W_CFG[i], o, aa, bb, ff, kk, exp_q[i], exp_f[i]);
        #1;
        for (int i = 0; i < 4; i++) check($sformatf("accept_rdy%0d", i), 32'(rv[i]), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic collect(input string tag);
        int lat [4];
        bit all;
        for (int i = 0; i < 4; i++) lat[i] = 0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            all = 1;
            for (int i = 0; i < 4; i++) begin
                if (vv[i] && lat[i] == 0) lat[i] = c;
                if (lat[i] == 0) all = 0;
            end
            if (all) break;
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_lat%0d", tag, i), 32'(lat[i]), 32'(W_CFG[i] / 8));
            check($sformatf("%s_q%0d", tag, i), qv[i], exp_q[i]);
            check($sformatf("%s_f%0d", tag, i), {24'b0, fv[i]}, {24'b0, exp_f[i]});
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("release_idle", 32'(vv[0]), 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 4))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h0;
            2:       return 32'h8000_8080;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] sq;
        logic [7:0]  sf;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; keep = 1'b0;
        op = '0; a = '0; b = '0; f_in = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_rdy%0d", i), 32'(rv[i]), 32'd1);
            check($sformatf("rst_vld%0d", i), 32'(vv[i]), 32'd0);
            check($sformatf("rst_q%0d", i), qv[i], 32'd0);
            check($sformatf("rst_f%0d", i), {24'b0, fv[i]}, 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;

        issue(4'd0, 32'h0FFF, 32'h1, 8'h00, 1'b0, 1'b0);
        collect("add");
        check("add_dir_q", qv[0], 32'h1000);
        check("add_dir_f", {24'b0, fv[0]}, 32'h20);
        release_out();

        issue(4'd2, 32'h0, 32'h1, 8'h00, 1'b0, 1'b0);
        collect("sub");
        check("sub_dir_q", qv[0], 32'hFFFF);
        check("sub_dir_f", {24'b0, fv[0]}, 32'h70);
        release_out();

        issue(4'd7, 32'h0, 32'h1, 8'h00, 1'b0, 1'b0);
        collect("cp");
        check("cp_dir_q", qv[0], 32'h0000);
        check("cp_dir_f", {24'b0, fv[0]}, 32'h70);
        release_out();

        issue(4'd3, 32'h8000, 32'h0, 8'h01, 1'b0, 1'b0);
        collect("sbc");
        check("sbc_dir_q", qv[1], 32'h7FFF);
        check("sbc_dir_f", {24'b0, fv[1]}, 32'h3E);
        release_out();

        issue(4'd0, 32'h80, 32'h80, 8'h00, 1'b0, 1'b0);
        collect("add8");
        check("add8_dir_q", qv[2], 32'h00);
        check("add8_dir_f", {24'b0, fv[2]}, 32'h90);
        release_out();

        issue(4'd1, 32'hFFFF_FFFF, 32'h0, 8'h11, 1'b0, 1'b0);
        collect("adc32");
        check("adc32_dir_q", qv[3], 32'h0);
        check("adc32_dir_f", {24'b0, fv[3]}, 32'h51);
        release_out();

        // Stalled result with a competing request, then back-to-back accept.
        issue(4'd0, 32'h1234_5678, 32'h1111_9999, 8'h00, 1'b0, 1'b0);
        collect("b2b1");
        sq = qv[0];
        sf = fv[0];
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1; op = 4'd5; a = $urandom; b = $urandom;
            @(posedge clk);
            #1;
            check("hold_q", qv[0], sq);
            check("hold_f", {24'b0, fv[0]}, {24'b0, sf});
            check("hold_vld", 32'(vv[0]), 32'd1);
            check("hold_rdy", 32'(rv[0]), 32'd0);
        end
        issue(4'd3, 32'hA5A5_0F0F, 32'h5A5A_F0F1, 8'h11, 1'b0, 1'b1);
        check("b2b_run", 32'(vv[0]), 32'd0);
        collect("b2b2");
        release_out();

        // Reset lands after byte 0 of a new operation.
        issue(4'd0, 32'h0F0F_0F0F, 32'h0101_0101, 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_vld", 32'(vv[0]), 32'd0);
        check("mid_rst_q", qv[0], 32'd0);
        check("mid_rst_f", {24'b0, fv[0]}, 32'd0);
        check("mid_rst_rdy", 32'(rv[0]), 32'd1);
        check("mid_rst_q3", qv[3], 32'd0);
        @(negedge clk);
        reset = 1'b0;
        issue(4'd9, 32'h0001_0000, 32'h0, 8'hFF, 1'b0, 1'b0);
        collect("post_rst");
        release_out();

        for (int n = 0; n < 40; n++) begin
            issue(4'($urandom_range(0, 15)), pick(), pick(), 8'($urandom),
                  ($urandom_range(0, 3) == 0), 1'b0);
            collect($sformatf("rnd%0d", n));
            release_out();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
